// File: rtl/csr_m_unit.sv
// M-mode CSR unit: interrupt lines, CSRRW/RS/RC access, trap/mret sequencing,
// vectored mtvec and 64-bit mcycle/minstret counters with inhibit.
module csr_m_unit #(
  parameter int unsigned NUM_LOCAL_IRQ = 16,
  parameter int unsigned RETIRE_WIDTH  = 2,
  parameter logic [31:0] HART_ID       = 32'h0,
  parameter logic [31:0] MTVEC_RESET   = 32'h0,
  localparam int unsigned LW  = (NUM_LOCAL_IRQ > 0) ? NUM_LOCAL_IRQ : 1,
  localparam int unsigned RCW = $clog2(RETIRE_WIDTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           irq_external,
  input  logic           irq_timer,
  input  logic           irq_software,
  input  logic [LW-1:0]  irq_local,
  input  logic           csr_valid,
  input  logic [1:0]     csr_op,
  input  logic [11:0]    csr_addr,
  input  logic [31:0]    csr_wdata,
  output logic [31:0]    csr_rdata,
  output logic           csr_illegal,
  input  logic           trap_en,
  input  logic [31:0]    trap_pc,
  input  logic [31:0]    trap_cause,
  input  logic [31:0]    trap_tval,
  input  logic           mret_en,
  input  logic [RCW-1:0] retire_cnt,
  output logic           irq_req,
  output logic [31:0]    irq_cause,
  output logic [31:0]    trap_target_pc,
  output logic [31:0]    mepc_pc,
  output logic           mstatus_mie
);

  localparam int unsigned WORD_WIDTH = 32;

  function automatic logic [WORD_WIDTH-1:0] local_mask();
    logic [WORD_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < int'(NUM_LOCAL_IRQ); i++) m[16+i] = 1'b1;
    return m;
  endfunction

  localparam logic [WORD_WIDTH-1:0] IRQ_MASK  = 32'h0000_0888 | local_mask();
  localparam logic [WORD_WIDTH-1:0] MISA_VAL  = 32'h4000_1100;
  localparam logic [WORD_WIDTH-1:0] MTVEC_RST = MTVEC_RESET & ~32'h2;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  logic                  mie_bit_q;
  logic                  mpie_bit_q;
  logic [WORD_WIDTH-1:0] mie_q;
  logic [WORD_WIDTH-1:0] mip_q;
  logic [WORD_WIDTH-1:0] mtvec_q;
  logic [WORD_WIDTH-1:0] minhibit_q;
  logic [WORD_WIDTH-1:0] mscratch_q;
  logic [WORD_WIDTH-1:0] mepc_q;
  logic [WORD_WIDTH-1:0] mcause_q;
  logic [WORD_WIDTH-1:0] mtval_q;
  logic [63:0]           mcycle_q;
  logic [63:0]           minstret_q;

  logic [WORD_WIDTH-1:0] mstatus_val;
  logic [WORD_WIDTH-1:0] rdata;
  logic [WORD_WIDTH-1:0] wval;
  logic [WORD_WIDTH-1:0] irq_lines;
  logic [WORD_WIDTH-1:0] pending;
  logic                  addr_known;
  logic                  addr_ro;
  logic                  write_attempt;
  logic                  we;
  logic                  any_pending;
  logic [4:0]            irq_code;

  assign mstatus_val = {19'b0, 2'b11, 3'b0, mpie_bit_q, 3'b0, mie_bit_q, 3'b0};

  always_comb begin
    rdata      = '0;
    addr_known = 1'b1;
    addr_ro    = 1'b0;
    case (csr_addr)
      12'h300: rdata = mstatus_val;
      12'h301: rdata = MISA_VAL;
      12'h304: rdata = mie_q;
      12'h305: rdata = mtvec_q;
      12'h320: rdata = minhibit_q;
      12'h340: rdata = mscratch_q;
      12'h341: rdata = mepc_q;
      12'h342: rdata = mcause_q;
      12'h343: rdata = mtval_q;
      12'h344: rdata = mip_q;
      12'hB00: rdata = mcycle_q[31:0];
      12'hB80: rdata = mcycle_q[63:32];
      12'hB02: rdata = minstret_q[31:0];
      12'hB82: rdata = minstret_q[63:32];
      12'hF11, 12'hF12, 12'hF13: addr_ro = 1'b1;
      12'hF14: begin
        addr_ro = 1'b1;
        rdata   = HART_ID;
      end
      default: addr_known = 1'b0;
    endcase
  end

  // RS/RC with a zero operand is a pure read, so it is legal even on read-only ids.
  assign write_attempt = csr_valid &&
                         ((csr_op == OP_RW) || (csr_op[1] && (csr_wdata != '0)));
  assign csr_illegal   = csr_valid && (!addr_known || (addr_ro && write_attempt));
  assign we            = write_attempt && !csr_illegal;
  assign csr_rdata     = rdata;

  always_comb begin
    case (csr_op)
      OP_RW:   wval = csr_wdata;
      OP_RS:   wval = rdata | csr_wdata;
      OP_RC:   wval = rdata & ~csr_wdata;
      default: wval = rdata;
    endcase
  end

  always_comb begin
    irq_lines     = '0;
    irq_lines[3]  = irq_software;
    irq_lines[7]  = irq_timer;
    irq_lines[11] = irq_external;
    for (int i = 0; i < int'(NUM_LOCAL_IRQ); i++) irq_lines[16+i] = irq_local[i];
  end

  assign pending     = mip_q & mie_q;
  assign any_pending = |pending;

  // Walk from lowest to highest priority so the winner is assigned last.
  always_comb begin
    irq_code = 5'd0;
    for (int i = int'(NUM_LOCAL_IRQ) - 1; i >= 0; i--) begin
      if (pending[16+i]) irq_code = 5'(16 + i);
    end
    if (pending[7])  irq_code = 5'd7;
    if (pending[3])  irq_code = 5'd3;
    if (pending[11]) irq_code = 5'd11;
  end

  always_comb begin
    trap_target_pc = {mtvec_q[31:2], 2'b00};
    if ((mtvec_q[1:0] == 2'b01) && trap_cause[31])
      trap_target_pc = {mtvec_q[31:2], 2'b00} + {25'b0, trap_cause[4:0], 2'b00};
  end

  assign mepc_pc     = mepc_q;
  assign mstatus_mie = mie_bit_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mie_bit_q  <= 1'b0;
      mpie_bit_q <= 1'b1;
      mie_q      <= '0;
      mip_q      <= '0;
      mtvec_q    <= MTVEC_RST;
      minhibit_q <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
      irq_req    <= 1'b0;
      irq_cause  <= '0;
    end else begin
      mip_q <= irq_lines & IRQ_MASK;

      if (we && csr_addr == 12'h304) mie_q      <= wval & IRQ_MASK;
      if (we && csr_addr == 12'h305) mtvec_q    <= wval & ~32'h2;
      if (we && csr_addr == 12'h320) minhibit_q <= wval & 32'h5;
      if (we && csr_addr == 12'h340) mscratch_q <= wval;

      // Trap beats mret beats CSR writes for the trap-owned registers.
      if (trap_en) begin
        mepc_q     <= {trap_pc[31:2], 2'b00};
        mcause_q   <= trap_cause;
        mtval_q    <= trap_tval;
        mpie_bit_q <= mie_bit_q;
        mie_bit_q  <= 1'b0;
      end else if (mret_en) begin
        mie_bit_q  <= mpie_bit_q;
        mpie_bit_q <= 1'b1;
      end else begin
        if (we && csr_addr == 12'h300) begin
          mie_bit_q  <= wval[3];
          mpie_bit_q <= wval[7];
        end
        if (we && csr_addr == 12'h341) mepc_q   <= {wval[31:2], 2'b00};
        if (we && csr_addr == 12'h342) mcause_q <= wval;
        if (we && csr_addr == 12'h343) mtval_q  <= wval;
      end

      irq_req   <= mie_bit_q && any_pending;
      irq_cause <= (mie_bit_q && any_pending) ? {1'b1, 26'b0, irq_code} : '0;

      // A write to either half suppresses the whole counter's increment that cycle.
      if (we && csr_addr == 12'hB00)      mcycle_q[31:0]  <= wval;
      else if (we && csr_addr == 12'hB80) mcycle_q[63:32] <= wval;
      else if (!minhibit_q[0])            mcycle_q        <= mcycle_q + 64'd1;

      if (we && csr_addr == 12'hB02)      minstret_q[31:0]  <= wval;
      else if (we && csr_addr == 12'hB82) minstret_q[63:32] <= wval;
      else if (!minhibit_q[2])            minstret_q        <= minstret_q + 64'(retire_cnt);
    end
  end

endmodule

// File: tb/tb_csr_m_unit.sv
// Scoreboard bench for csr_m_unit: stimulus queues expected CSR reads and output
// probes; a negedge monitor pops and compares whenever an access or probe is presented.
module tb_csr_m_unit;

  localparam logic [1:0] OP_R = 2'b00;
  localparam logic [1:0] OP_W = 2'b01;
  localparam logic [1:0] OP_S = 2'b10;
  localparam logic [1:0] OP_C = 2'b11;

  localparam int P_MIE   = 0;
  localparam int P_REQ   = 1;
  localparam int P_CAUSE = 2;
  localparam int P_TGT   = 3;
  localparam int P_MEPC  = 4;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        illegal;
    bit          chk_rdata;
  } csr_exp_t;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } probe_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        irq_external = 1'b0;
  logic        irq_timer = 1'b0;
  logic        irq_software = 1'b0;
  logic [15:0] irq_local = '0;
  logic        csr_valid = 1'b0;
  logic [1:0]  csr_op = '0;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        trap_en = 1'b0;
  logic [31:0] trap_pc = '0;
  logic [31:0] trap_cause = '0;
  logic [31:0] trap_tval = '0;
  logic        mret_en = 1'b0;
  logic [1:0]  retire_cnt = '0;
  logic        irq_req;
  logic [31:0] irq_cause;
  logic [31:0] trap_target_pc;
  logic [31:0] mepc_pc;
  logic        mstatus_mie;

  logic        probe_en = 1'b0;
  int          checks = 0;
  int          errors = 0;
  csr_exp_t    csr_q[$];
  probe_exp_t  probe_q[$];

  csr_m_unit #(
    .NUM_LOCAL_IRQ(16),
    .RETIRE_WIDTH (2),
    .HART_ID      (32'h5),
    .MTVEC_RESET  (32'h103)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .irq_external  (irq_external),
    .irq_timer     (irq_timer),
    .irq_software  (irq_software),
    .irq_local     (irq_local),
    .csr_valid     (csr_valid),
    .csr_op        (csr_op),
    .csr_addr      (csr_addr),
    .csr_wdata     (csr_wdata),
    .csr_rdata     (csr_rdata),
    .csr_illegal   (csr_illegal),
    .trap_en       (trap_en),
    .trap_pc       (trap_pc),
    .trap_cause    (trap_cause),
    .trap_tval     (trap_tval),
    .mret_en       (mret_en),
    .retire_cnt    (retire_cnt),
    .irq_req       (irq_req),
    .irq_cause     (irq_cause),
    .trap_target_pc(trap_target_pc),
    .mepc_pc       (mepc_pc),
    .mstatus_mie   (mstatus_mie)
  );

  always #5 clk = ~clk;

  // Monitor
  always @(negedge clk) begin
    csr_exp_t    ce;
    probe_exp_t  pe;
    logic [31:0] act;
    if (csr_valid) begin
      checks++;
      if (csr_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_csr addr=%h actual=%h required=<no entry>", csr_addr, csr_rdata);
      end else begin
        ce = csr_q.pop_front();
        if (csr_illegal !== ce.illegal) begin
          errors++;
          $display("FAIL %s illegal actual=%0b required=%0b", ce.name, csr_illegal, ce.illegal);
        end
        if (ce.chk_rdata) begin
          checks++;
          if (csr_rdata !== ce.rdata) begin
            errors++;
            $display("FAIL %s rdata actual=%h required=%h", ce.name, csr_rdata, ce.rdata);
          end
        end
      end
    end
    if (probe_en) begin
      checks++;
      if (probe_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_probe actual=<probe> required=<no entry>");
      end else begin
        pe = probe_q.pop_front();
        case (pe.sel)
          P_MIE:   act = {31'b0, mstatus_mie};
          P_REQ:   act = {31'b0, irq_req};
          P_CAUSE: act = irq_cause;
          P_TGT:   act = trap_target_pc;
          default: act = mepc_pc;
        endcase
        if (act !== pe.val) begin
          errors++;
          $display("FAIL %s actual=%h required=%h", pe.name, act, pe.val);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    csr_valid = 1'b0;
    csr_op    = OP_R;
    csr_wdata = '0;
    probe_en  = 1'b0;
  endtask

  task automatic csr_set(input string n, input logic [1:0] op, input logic [11:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd,
                         input logic exp_ill, input bit chk);
    csr_valid = 1'b1;
    csr_op    = op;
    csr_addr  = a;
    csr_wdata = wd;
    csr_q.push_back('{name: n, rdata: exp_rd, illegal: exp_ill, chk_rdata: chk});
  endtask

  task automatic csr(input string n, input logic [1:0] op, input logic [11:0] a,
                     input logic [31:0] wd, input logic [31:0] exp_rd,
                     input logic exp_ill, input bit chk);
    csr_set(n, op, a, wd, exp_rd, exp_ill, chk);
    tick();
  endtask

  task automatic probe(input string n, input int sel, input logic [31:0] v);
    probe_en = 1'b1;
    probe_q.push_back('{name: n, sel: sel, val: v});
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    csr("rst_mstatus", OP_R, 12'h300, 0, 32'h1880, 0, 1);
    csr("rst_mtvec",   OP_R, 12'h305, 0, 32'h101,  0, 1);
    csr("rst_mie",     OP_R, 12'h304, 0, 32'h0,    0, 1);
    csr("rst_mepc",    OP_R, 12'h341, 0, 32'h0,    0, 1);
    probe("rst_mie_out",   P_MIE,   32'h0);
    probe("rst_irq_req",   P_REQ,   32'h0);
    probe("rst_irq_cause", P_CAUSE, 32'h0);

    // Handler address, vectored and exception
    trap_cause = 32'h8000_0003;
    probe("vec_target", P_TGT, 32'h10C);
    trap_cause = 32'h3;
    probe("exc_target", P_TGT, 32'h100);
    trap_cause = 32'h0;

    // Set/clear MIE
    csr("rs_mstatus", OP_S, 12'h300, 32'h8, 32'h1880, 0, 1);
    probe("rs_mie_out", P_MIE, 32'h1);
    csr("rc_mstatus", OP_C, 12'h300, 32'h8, 32'h1888, 0, 1);
    probe("rc_mie_out", P_MIE, 32'h0);

    // Legality
    csr("rw_mhartid",   OP_W, 12'hF14, 32'h77, 32'h5, 1, 1);
    csr("rs0_mhartid",  OP_S, 12'hF14, 32'h0,  32'h5, 0, 1);
    csr("rd_mvendor",   OP_R, 12'hF11, 32'h0,  32'h0, 0, 1);
    csr("rs_mvendor",   OP_S, 12'hF11, 32'h1,  32'h0, 1, 0);
    csr("unknown_addr", OP_R, 12'h7FF, 32'h0,  32'h0, 1, 0);
    csr("rs_misa",      OP_S, 12'h301, 32'h1,  32'h0, 0, 0);
    csr("rw_mip",       OP_W, 12'h344, 32'hFFFF_FFFF, 32'h0, 0, 1);
    csr("rd_mip",       OP_R, 12'h344, 32'h0,  32'h0, 0, 1);

    // Write masks
    csr("rw_mstatus_ones", OP_W, 12'h300, 32'hFFFF_FFFF, 32'h1880, 0, 1);
    csr("mstatus_mask",    OP_R, 12'h300, 32'h0,         32'h1888, 0, 1);
    csr("rw_mstatus_zero", OP_W, 12'h300, 32'h0,         32'h1888, 0, 1);
    csr("mstatus_mpp",     OP_R, 12'h300, 32'h0,         32'h1800, 0, 1);
    csr("rw_mepc",         OP_W, 12'h341, 32'h1234_5677, 32'h0, 0, 1);
    csr("mepc_align",      OP_R, 12'h341, 32'h0, 32'h1234_5674, 0, 1);
    probe("mepc_out", P_MEPC, 32'h1234_5674);
    csr("rw_mie_ones",     OP_W, 12'h304, 32'hFFFF_FFFF, 32'h0, 0, 1);
    csr("mie_mask",        OP_R, 12'h304, 32'h0, 32'hFFFF_0888, 0, 1);
    csr("rw_minh",         OP_W, 12'h320, 32'hFF, 32'h0, 0, 1);
    csr("minh_mask",       OP_R, 12'h320, 32'h0,  32'h5, 0, 1);
    csr("rw_minh_clr",     OP_W, 12'h320, 32'h0,  32'h5, 0, 1);

    // minstret increment and inhibit
    retire_cnt = 2'd2;
    csr("minstret_0",    OP_R, 12'hB02, 0, 32'h0, 0, 1);
    csr("minstret_2",    OP_R, 12'hB02, 0, 32'h2, 0, 1);
    csr("rw_minh_4",     OP_W, 12'h320, 32'h4, 32'h0, 0, 1);
    csr("minstret_6",    OP_R, 12'hB02, 0, 32'h6, 0, 1);
    csr("minstret_hold", OP_R, 12'hB02, 0, 32'h6, 0, 1);
    retire_cnt = 2'd0;

    // mcycle inhibit
    csr("rw_minh_5",   OP_W, 12'h320, 32'h5,   32'h4, 0, 1);
    csr("rw_mcycle",   OP_W, 12'hB00, 32'h100, 32'h0, 0, 0);
    csr("mcycle_inh",  OP_R, 12'hB00, 0, 32'h100, 0, 1);
    csr("mcycle_inh2", OP_R, 12'hB00, 0, 32'h100, 0, 1);
    csr("rw_minh_0",   OP_W, 12'h320, 32'h0,   32'h5, 0, 1);
    csr("mcycle_run0", OP_R, 12'hB00, 0, 32'h100, 0, 1);
    csr("mcycle_run1", OP_R, 12'hB00, 0, 32'h101, 0, 1);

    // 64-bit wrap
    csr("rw_mcycle_lo", OP_W, 12'hB00, 32'hFFFF_FFFF, 32'h0, 0, 0);
    csr("rw_mcycle_hi", OP_W, 12'hB80, 32'hFFFF_FFFF, 32'h0, 0, 1);
    csr("mcycleh_pre",  OP_R, 12'hB80, 0, 32'hFFFF_FFFF, 0, 1);
    csr("mcycle_wrap",  OP_R, 12'hB00, 0, 32'h0, 0, 1);
    csr("mcycleh_wrap", OP_R, 12'hB80, 0, 32'h0, 0, 1);

    // Local interrupt, vectored trap, mret
    csr("rw_mtvec",       OP_W, 12'h305, 32'h1001,  32'h101, 0, 1);
    csr("mtvec_rd",       OP_R, 12'h305, 0,         32'h1001, 0, 1);
    csr("rw_mie_16",      OP_W, 12'h304, 32'h10000, 32'hFFFF_0888, 0, 1);
    csr("rs_mstatus_mie", OP_S, 12'h300, 32'h8,     32'h1800, 0, 1);
    irq_local = 16'h0001;
    probe("irq_lat0", P_REQ, 32'h0);
    probe("irq_lat1", P_REQ, 32'h0);
    probe("irq_lat2", P_REQ, 32'h1);
    probe("irq_cause_local", P_CAUSE, 32'h8000_0010);
    trap_en    = 1'b1;
    trap_pc    = 32'h2003;
    trap_cause = 32'h8000_0010;
    trap_tval  = 32'h0;
    probe("trap_target", P_TGT, 32'h1040);
    trap_en = 1'b0;
    probe("trap_mie", P_MIE, 32'h0);
    csr("trap_mstatus", OP_R, 12'h300, 0, 32'h1880, 0, 1);
    probe("irq_req_drop", P_REQ, 32'h0);
    csr("trap_mepc",   OP_R, 12'h341, 0, 32'h2000, 0, 1);
    csr("trap_mcause", OP_R, 12'h342, 0, 32'h8000_0010, 0, 1);
    irq_local = 16'h0;
    mret_en = 1'b1;
    tick();
    mret_en = 1'b0;
    probe("mret_mie", P_MIE, 32'h1);
    csr("mret_mstatus", OP_R, 12'h300, 0, 32'h1888, 0, 1);

    // Standard interrupt priority
    csr("rw_mie_ext_tim", OP_W, 12'h304, 32'h880, 32'h10000, 0, 1);
    irq_external = 1'b1;
    irq_timer    = 1'b1;
    tick();
    tick();
    probe("cause_ext", P_CAUSE, 32'h8000_000B);
    irq_external = 1'b0;
    tick();
    tick();
    probe("cause_tim", P_CAUSE, 32'h8000_0007);
    csr("rs_mie_sw", OP_S, 12'h304, 32'h8, 32'h880, 0, 1);
    irq_software = 1'b1;
    tick();
    tick();
    probe("cause_sw", P_CAUSE, 32'h8000_0003);
    irq_software = 1'b0;
    irq_timer    = 1'b0;

    // trap > mret > CSR write
    trap_en    = 1'b1;
    mret_en    = 1'b1;
    trap_pc    = 32'h3006;
    trap_cause = 32'h5;
    trap_tval  = 32'hABC;
    csr_set("prio_mepc_rw", OP_W, 12'h341, 32'hDEAD_0000, 32'h2000, 0, 1);
    tick();
    trap_en = 1'b0;
    mret_en = 1'b0;
    csr("prio_mepc",    OP_R, 12'h341, 0, 32'h3004, 0, 1);
    csr("prio_mcause",  OP_R, 12'h342, 0, 32'h5,    0, 1);
    csr("prio_mtval",   OP_R, 12'h343, 0, 32'hABC,  0, 1);
    csr("prio_mstatus", OP_R, 12'h300, 0, 32'h1880, 0, 1);

    // Writes to non-trap registers still land during a trap
    trap_en    = 1'b1;
    trap_pc    = 32'h4000;
    trap_cause = 32'h2;
    trap_tval  = 32'h0;
    csr_set("trap_mscratch_rw", OP_W, 12'h340, 32'h55, 32'h0, 0, 1);
    tick();
    trap_en = 1'b0;
    csr("trap_mscratch", OP_R, 12'h340, 0, 32'h55,   0, 1);
    csr("trap2_mepc",    OP_R, 12'h341, 0, 32'h4000, 0, 1);

    // Reset mid-sequence
    csr("rs_mstatus_pre", OP_S, 12'h300, 32'h8, 32'h1800, 0, 1);
    csr("rw_minh_pre",    OP_W, 12'h320, 32'h5, 32'h0,    0, 1);
    rst     = 1'b1;
    trap_en = 1'b1;
    csr_set("rst_drop_rw", OP_W, 12'h340, 32'h99, 32'h55, 0, 1);
    tick();
    rst     = 1'b0;
    trap_en = 1'b0;
    csr("rst2_mcycle",   OP_R, 12'hB00, 0, 32'h0,    0, 1);
    csr("rst2_mscratch", OP_R, 12'h340, 0, 32'h0,    0, 1);
    csr("rst2_mstatus",  OP_R, 12'h300, 0, 32'h1880, 0, 1);
    csr("rst2_mtvec",    OP_R, 12'h305, 0, 32'h101,  0, 1);
    csr("rst2_mie",      OP_R, 12'h304, 0, 32'h0,    0, 1);
    csr("rst2_mepc",     OP_R, 12'h341, 0, 32'h0,    0, 1);
    csr("rst2_minh",     OP_R, 12'h320, 0, 32'h0,    0, 1);
    probe("rst2_mie_out", P_MIE, 32'h0);
    probe("rst2_irq_req", P_REQ, 32'h0);

    tick();
    tick();
    checks++;
    if (csr_q.size() != 0 || probe_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", csr_q.size() + probe_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
